// File: rtl/cmd_responder.sv
// Command-channel responder: one outstanding read/write against an internal word memory,
// answered with data, status and echoed id after RESP_LAT wait cycles.
module cmd_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
    parameter int                    RESP_LAT   = 1,
    parameter int                    MAX_TRANS  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    input  logic [3:0]                    req_id,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_status,
    output logic [3:0]                    rsp_id,
    output logic [$clog2(MAX_TRANS)-1:0]  trans_count
);
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);
    localparam int CNT_BITS = $clog2(MAX_TRANS);
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));
    localparam logic [3:0] LAT_INIT = (RESP_LAT > 0) ? 4'(RESP_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             lat_cnt_reg, lat_cnt_next;
    logic [1:0]             status_reg;
    logic [3:0]             id_reg;
    logic                   rd_hit_reg;
    logic [DATA_WIDTH-1:0]  rd_word_reg;
    logic [CNT_BITS-1:0]    trans_count_reg;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]   written;

    logic                   accept;
    logic                   rsp_fire;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   addr_ok;
    logic                   mem_we;
    logic [ADDR_WIDTH:0]    addr_ext;
    logic [IDX_BITS-1:0]    word_idx;
    logic [1:0]             dec_status;

    assign req_ready = (state_reg == IDLE) && !rst;
    assign rsp_valid = (state_reg == RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // One extra address bit keeps BASE+size from wrapping at the top of the space.
    assign addr_ext     = {1'b0, req_addr};
    assign misaligned   = |req_addr[OFF_BITS-1:0];
    assign out_of_range = (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);
    assign addr_ok      = !misaligned && !out_of_range;
    assign word_idx     = IDX_BITS'((addr_ext - BASE_EXT) >> OFF_BITS);
    assign dec_status   = misaligned ? 2'b10 : (out_of_range ? 2'b11 : 2'b00);
    assign mem_we       = accept && req_write && addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    lat_cnt_next = LAT_INIT;
                    state_next   = (RESP_LAT > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (lat_cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-word "ever written" flags give a single-cycle memory clear while the
    // data array itself stays a plain reset-free RAM.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_written
            logic written_bit_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    written_bit_reg <= 1'b0;
                end else if (mem_we && (word_idx == IDX_BITS'(gi))) begin
                    written_bit_reg <= 1'b1;
                end
            end
            assign written[gi] = written_bit_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= req_wdata;
        end
        if (accept) begin
            rd_word_reg <= mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg      <= 2'b00;
            id_reg          <= 4'd0;
            rd_hit_reg      <= 1'b0;
            trans_count_reg <= '0;
        end else begin
            if (accept) begin
                status_reg <= dec_status;
                id_reg     <= req_id;
                rd_hit_reg <= !req_write && addr_ok && written[word_idx];
            end
            if (rsp_fire) begin
                if (trans_count_reg == CNT_BITS'(MAX_TRANS - 1)) begin
                    trans_count_reg <= '0;
                end else begin
                    trans_count_reg <= trans_count_reg + 1'b1;
                end
            end
        end
    end

    assign rsp_rdata   = rd_hit_reg ? rd_word_reg : '0;
    assign rsp_status  = status_reg;
    assign rsp_id      = id_reg;
    assign trans_count = trans_count_reg;

endmodule

// File: tb/tb_cmd_responder.sv
// Bench for cmd_responder: transaction-level reference model with per-cycle output
// comparison, plus directed transactions carrying hand-computed expectations.
module tb_cmd_responder;
    localparam int          RESP_LAT  = 1;
    localparam int          MAX_TRANS = 1024;
    localparam int          MEM_DEPTH = 256;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam logic [63:0] PATTERN   = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [3:0]  rsp_id;
    logic [9:0]  trans_count;

    int vectors = 0;
    int miscompares = 0;

    cmd_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE),
        .RESP_LAT(RESP_LAT), .MAX_TRANS(MAX_TRANS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .rsp_id(rsp_id), .trans_count(trans_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  status;
        logic [3:0]  id;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mmem [int];
    int          mcount = 0;
    int          cyc = 0;
    bit          started = 0;

    always @(posedge clk) begin : model_blk
        bit      fire;
        bit      acc_now;
        exp_t    e;
        longint  a;
        int      idx;
        fire    = !rst && (q.size() > 0) && (cyc >= q[0].acc + RESP_LAT) && rsp_ready;
        acc_now = !rst && (q.size() == 0) && req_valid;
        cyc++;
        if (rst) begin
            started = 1;
            q.delete();
            mmem.delete();
            mcount = 0;
        end else if (fire) begin
            void'(q.pop_front());
            mcount = (mcount + 1) % MAX_TRANS;
        end else if (acc_now) begin
            a   = longint'(req_addr);
            idx = int'((a - longint'(BASE)) / 8);
            e.id  = req_id;
            e.acc = cyc;
            e.rdata = '0;
            if (a % 8 != 0)                                                    e.status = 2'b10;
            else if (a < longint'(BASE) || a >= longint'(BASE) + MEM_DEPTH * 8) e.status = 2'b11;
            else                                                               e.status = 2'b00;
            if (e.status == 2'b00) begin
                if (req_write)            mmem[idx] = req_wdata;
                else if (mmem.exists(idx)) e.rdata = mmem[idx];
            end
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : compare_blk
        bit exp_valid;
        if (started) begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + RESP_LAT);
            chk("req_ready", req_ready, !rst && (q.size() == 0));
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("trans_count", trans_count, mcount);
            if (exp_valid) begin
                chk("rsp_rdata", rsp_rdata, q[0].rdata);
                chk("rsp_status", rsp_status, q[0].status);
                chk("rsp_id", rsp_id, q[0].id);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [3:0] id);
        bit got = 0;
        req_write = w; req_addr = a; req_wdata = d; req_id = id; req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) tmo("accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [3:0] id,
                        output logic [63:0] rd, output logic [1:0] st, output logic [3:0] rid, output int lat);
        bit got = 0;
        send(w, a, d, id);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin got = 1; break; end
        end
        if (!got) tmo("response");
        rd = rsp_rdata; st = rsp_status; rid = rsp_id;
        $display("txn %s addr=%08h id=%0d -> status=%0b rdata=%016h lat=%0d",
                 w ? "WR" : "RD", a, id, st, rd, lat);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin got = 1; break; end
        end
        if (!got) tmo("idle");
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] rd;
        logic [1:0]  st;
        logic [3:0]  rid;
        int          lat;
        int          acc_prev;
        bit          got;
        logic [31:0] e_addr [4];
        logic        e_wr   [4];
        logic [1:0]  e_st   [4];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", req_ready, 1'b0);
        chk("rst rsp_valid", rsp_valid, 1'b0);
        chk("rst rsp_rdata", rsp_rdata, 64'd0);
        chk("rst rsp_status", rsp_status, 2'b00);
        chk("rst rsp_id", rsp_id, 4'd0);
        chk("rst trans_count", trans_count, 10'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        // Write then read back
        xact(1'b1, 32'h1008, PATTERN, 4'd3, rd, st, rid, lat);
        chk("wr status", st, 2'b00);
        chk("wr id", rid, 4'd3);
        chk("wr rdata", rd, 64'd0);
        chk("wr latency", lat, 2);
        xact(1'b0, 32'h1008, 64'd0, 4'd5, rd, st, rid, lat);
        chk("rd rdata", rd, PATTERN);
        chk("rd status", st, 2'b00);
        chk("rd id", rid, 4'd5);
        chk("rd latency", lat, 2);
        chk("count after 2", trans_count, 10'd2);

        // Misaligned / out of range, then confirm memory untouched
        e_addr[0] = 32'h1004; e_wr[0] = 1'b1; e_st[0] = 2'b10;
        e_addr[1] = 32'h0FF8; e_wr[1] = 1'b0; e_st[1] = 2'b11;
        e_addr[2] = 32'h1800; e_wr[2] = 1'b0; e_st[2] = 2'b11;
        e_addr[3] = 32'h1000; e_wr[3] = 1'b0; e_st[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            xact(e_wr[i], e_addr[i], 64'hFFFF_FFFF_FFFF_FFFF, 4'(i), rd, st, rid, lat);
            chk("err status", st, e_st[i]);
            chk("err rdata", rd, 64'd0);
        end

        // Boundary words
        xact(1'b1, 32'h1000, 64'd1, 4'd1, rd, st, rid, lat);
        xact(1'b1, 32'h17F8, 64'd2, 4'd2, rd, st, rid, lat);
        xact(1'b0, 32'h1000, 64'd0, 4'd4, rd, st, rid, lat);
        chk("first word", rd, 64'd1);
        chk("first status", st, 2'b00);
        xact(1'b0, 32'h17F8, 64'd0, 4'd6, rd, st, rid, lat);
        chk("last word", rd, 64'd2);
        chk("last status", st, 2'b00);

        // Backpressure
        rsp_ready = 1'b0;
        send(1'b0, 32'h1008, 64'd0, 4'd7);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        if (!got) tmo("bp response");
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", rsp_valid, 1'b1);
            chk("bp rdata", rsp_rdata, PATTERN);
            chk("bp status", rsp_status, 2'b00);
            chk("bp id", rsp_id, 4'd7);
            chk("bp req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp done rsp_valid", rsp_valid, 1'b0);
        chk("bp done req_ready", req_ready, 1'b1);
        $display("txn RD addr=00001008 id=7 held 5 cycles under backpressure");

        // Counter wrap from a fresh reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        acc_prev = 0;
        for (int j = 1; j <= 1025; j++) begin
            send(1'b0, 32'h1000, 64'd0, 4'(j));
            if (j > 1) chk("spacing", cyc - acc_prev, RESP_LAT + 2);
            acc_prev = cyc;
            if (j == 1024) chk("count 1023", trans_count, 10'd1023);
            if (j == 1025) chk("count wrap 0", trans_count, 10'd0);
        end
        wait_idle();
        chk("count 1", trans_count, 10'd1);
        $display("txn 1025 back-to-back reads, trans_count=%0d", trans_count);

        // Reset while waiting on a write
        send(1'b1, 32'h1010, 64'h1234_5678_9ABC_DEF0, 4'd9);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid-rst req_ready", req_ready, 1'b1);
        chk("mid-rst rsp_valid after", rsp_valid, 1'b0);
        chk("mid-rst trans_count", trans_count, 10'd0);
        @(posedge clk); #1;
        xact(1'b0, 32'h1010, 64'd0, 4'd10, rd, st, rid, lat);
        chk("mid-rst readback", rd, 64'd0);
        chk("mid-rst status", st, 2'b00);
        chk("mid-rst id", rid, 4'd10);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
